// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: IR field positions, opcodes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package control_sequencer_pkg;

    // Instruction register field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;
    localparam int C_LSB   = 0;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LD   = 5'd0;
    localparam opcode_t OP_LDI  = 5'd1;
    localparam opcode_t OP_ST   = 5'd2;
    localparam opcode_t OP_ADD  = 5'd3;
    localparam opcode_t OP_SUB  = 5'd4;
    localparam opcode_t OP_AND  = 5'd5;
    localparam opcode_t OP_OR   = 5'd6;
    localparam opcode_t OP_SHR  = 5'd7;
    localparam opcode_t OP_SHRA = 5'd8;
    localparam opcode_t OP_SHL  = 5'd9;
    localparam opcode_t OP_ROR  = 5'd10;
    localparam opcode_t OP_ROL  = 5'd11;
    localparam opcode_t OP_ADDI = 5'd12;
    localparam opcode_t OP_ANDI = 5'd13;
    localparam opcode_t OP_ORI  = 5'd14;
    localparam opcode_t OP_DIV  = 5'd15;
    localparam opcode_t OP_MUL  = 5'd16;
    localparam opcode_t OP_NEG  = 5'd17;
    localparam opcode_t OP_NOT  = 5'd18;
    localparam opcode_t OP_MFHI = 5'd24;
    localparam opcode_t OP_MFLO = 5'd25;
    localparam opcode_t OP_NOP  = 5'd26;
    localparam opcode_t OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

endpackage

// File: rtl/reg_field_decoder.sv
// Converts a 4-bit register field into a 16-bit one-hot register vector.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: field (4-bit register number) -> one_hot (bit [field] set).
module reg_field_decoder (
    input  logic [3:0]  field,
    output logic [15:0] one_hot
);

    assign one_hot = 16'd1 << field;

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM (T0..T7, HALT) driving datapath enables/selects for fetch and execute.
// Latency: fetch 3 cycles, execute 1..5 cycles; outputs decode from state, IR and wait counter.
// Backpressure: memory steps hold while mem_ready=0; timeout after WAIT_LIMIT held cycles halts with mem_error.
//
// Ports: clk, clr (async active-low), IR_Data (current instruction), mem_ready;
//        r_enable/r_select (one-hot register in/out), datapath load enables, bus-source selects,
//        read/write memory requests, alu_instruction, run, illegal_op, mem_error.
// Build option: define MUL_DIV_EN to execute mul/div; otherwise they are illegal opcodes.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        mem_ready,
    output logic [15:0] r_enable,
    output logic [15:0] r_select,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        PC_select,
    output logic        HI_select,
    output logic        LO_select,
    output logic        Z_HI_select,
    output logic        Z_LO_select,
    output logic        MDR_select,
    output logic        c_select,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_instruction,
    output logic        run,
    output logic        illegal_op,
    output logic        mem_error
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t      state, next;
    logic        active;       // low in reset and until the first edge after release
    logic [7:0]  wait_cnt;
    logic        mem_error_q;
    logic        is_wait;      // current step waits on mem_ready
    state_t      adv;          // where a wait step goes once memory completes
    logic        timeout;
    logic        ra_in, ra_out, rb_out, rc_out;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    opcode_t     op;
    logic        unused_ir;

    assign op        = IR_Data[OPC_MSB:OPC_LSB];
    assign unused_ir = ^IR_Data[C_MSB-4:C_LSB];

    reg_field_decoder u_dec_ra (.field(IR_Data[RA_MSB:RA_LSB]), .one_hot(ra_hot));
    reg_field_decoder u_dec_rb (.field(IR_Data[RB_MSB:RB_LSB]), .one_hot(rb_hot));
    reg_field_decoder u_dec_rc (.field(IR_Data[RC_MSB:RC_LSB]), .one_hot(rc_hot));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= S_T0;
            active      <= 1'b0;
            wait_cnt    <= 8'd0;
            mem_error_q <= 1'b0;
        end else begin
            active <= 1'b1;
            state  <= next;
            if (next != state || !is_wait)
                wait_cnt <= 8'd0;
            else if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            if (timeout)
                mem_error_q <= 1'b1;
        end
    end

    always_comb begin
        next                = state;
        is_wait             = 1'b0;
        adv                 = S_T0;
        timeout             = 1'b0;
        ra_in               = 1'b0;
        ra_out              = 1'b0;
        rb_out              = 1'b0;
        rc_out              = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        HI_enable           = 1'b0;
        LO_enable           = 1'b0;
        PC_select           = 1'b0;
        HI_select           = 1'b0;
        LO_select           = 1'b0;
        Z_HI_select         = 1'b0;
        Z_LO_select         = 1'b0;
        MDR_select          = 1'b0;
        c_select            = 1'b0;
        read                = 1'b0;
        write               = 1'b0;
        alu_instruction     = 5'd0;
        illegal_op          = 1'b0;

        if (!active) begin
            next = S_T0;
        end else begin
            case (state)
                S_T0: begin
                    PC_select           = 1'b1;
                    MAR_enable          = 1'b1;
                    PC_increment_enable = 1'b1;
                    next                = S_T1;
                end
                S_T1: begin
                    read       = 1'b1;
                    MDR_enable = 1'b1;
                    is_wait    = 1'b1;
                    adv        = S_T2;
                end
                S_T2: begin
                    MDR_select = 1'b1;
                    IR_enable  = 1'b1;
                    next       = S_T3;
                end
                S_T3: begin
                    next = S_T4;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
                            rb_out   = 1'b1;
                            Y_enable = 1'b1;
                        end
                        OP_NEG, OP_NOT: begin
                            rb_out          = 1'b1;
                            alu_instruction = op;
                            Z_enable        = 1'b1;
                        end
                        OP_MFHI: begin
                            HI_select = 1'b1;
                            ra_in     = 1'b1;
                            next      = S_T0;
                        end
                        OP_MFLO: begin
                            LO_select = 1'b1;
                            ra_in     = 1'b1;
                            next      = S_T0;
                        end
                        OP_NOP:  next = S_T0;
                        OP_HALT: next = S_HALT;
`ifdef MUL_DIV_EN
                        OP_MUL, OP_DIV: begin
                            ra_out   = 1'b1;
                            Y_enable = 1'b1;
                        end
`endif
                        default: begin
                            illegal_op = 1'b1;
                            next       = S_T0;
                        end
                    endcase
                end
                S_T4: begin
                    next = S_T5;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                            rc_out          = 1'b1;
                            alu_instruction = op;
                            Z_enable        = 1'b1;
                        end
                        // ld/st address and ldi value are Rb + C
                        OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                            c_select        = 1'b1;
                            alu_instruction = OP_ADD;
                            Z_enable        = 1'b1;
                        end
                        OP_ANDI: begin
                            c_select        = 1'b1;
                            alu_instruction = OP_AND;
                            Z_enable        = 1'b1;
                        end
                        OP_ORI: begin
                            c_select        = 1'b1;
                            alu_instruction = OP_OR;
                            Z_enable        = 1'b1;
                        end
                        OP_NEG, OP_NOT: begin
                            Z_LO_select = 1'b1;
                            ra_in       = 1'b1;
                            next        = S_T0;
                        end
`ifdef MUL_DIV_EN
                        OP_MUL, OP_DIV: begin
                            rb_out          = 1'b1;
                            alu_instruction = op;
                            Z_enable        = 1'b1;
                        end
`endif
                        default: next = S_T0;
                    endcase
                end
                S_T5: begin
                    next = S_T0;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                            Z_LO_select = 1'b1;
                            ra_in       = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            Z_LO_select = 1'b1;
                            MAR_enable  = 1'b1;
                            next        = S_T6;
                        end
`ifdef MUL_DIV_EN
                        OP_MUL, OP_DIV: begin
                            Z_LO_select = 1'b1;
                            LO_enable   = 1'b1;
                            next        = S_T6;
                        end
`endif
                        default: next = S_T0;
                    endcase
                end
                S_T6: begin
                    next = S_T0;
                    case (op)
                        OP_LD: begin
                            read       = 1'b1;
                            MDR_enable = 1'b1;
                            is_wait    = 1'b1;
                            adv        = S_T7;
                        end
                        // store data goes through MDR from the bus, not from memory
                        OP_ST: begin
                            ra_out     = 1'b1;
                            MDR_enable = 1'b1;
                            next       = S_T7;
                        end
`ifdef MUL_DIV_EN
                        OP_MUL, OP_DIV: begin
                            Z_HI_select = 1'b1;
                            HI_enable   = 1'b1;
                        end
`endif
                        default: next = S_T0;
                    endcase
                end
                S_T7: begin
                    next = S_T0;
                    case (op)
                        OP_LD: begin
                            MDR_select = 1'b1;
                            ra_in      = 1'b1;
                        end
                        OP_ST: begin
                            write   = 1'b1;
                            is_wait = 1'b1;
                            adv     = S_T0;
                        end
                        default: next = S_T0;
                    endcase
                end
                S_HALT:  next = S_HALT;
                default: next = S_T0;
            endcase

            // Memory steps: advance on completion, otherwise hold until the counter hits the limit.
            if (is_wait) begin
                if (mem_ready) begin
                    next = adv;
                end else if (wait_cnt >= LIMIT) begin
                    next    = S_HALT;
                    timeout = 1'b1;
                end else begin
                    next = state;
                end
            end
        end
    end

    assign r_enable  = ra_in  ? ra_hot : 16'd0;
    assign r_select  = ra_out ? ra_hot :
                       rb_out ? rb_hot :
                       rc_out ? rc_hot : 16'd0;
    assign run       = active && (state != S_HALT);
    assign mem_error = mem_error_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] IR_Data;
    logic        mem_ready;
    logic [15:0] r_enable, r_select;
    logic        PC_increment_enable, IR_enable, Y_enable, Z_enable;
    logic        MAR_enable, MDR_enable, HI_enable, LO_enable;
    logic        PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select, c_select;
    logic        read, write, run, illegal_op, mem_error;
    logic [4:0]  alu_instruction;

    int checks;
    int errors;

    control_sequencer #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready),
        .r_enable(r_enable), .r_select(r_select),
        .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .PC_select(PC_select), .HI_select(HI_select), .LO_select(LO_select),
        .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .c_select(c_select), .read(read), .write(write),
        .alu_instruction(alu_instruction), .run(run), .illegal_op(illegal_op),
        .mem_error(mem_error)
    );

    // every output except run, concatenated for all-zero checks
    logic [55:0] outs;
    assign outs = {r_enable, r_select, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                   MAR_enable, MDR_enable, HI_enable, LO_enable, PC_select, HI_select,
                   LO_select, Z_HI_select, Z_LO_select, MDR_select, c_select, read, write,
                   alu_instruction, illegal_op, mem_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; sample point is 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // pulse reset and land in the first T0 cycle
    task automatic restart();
        clr = 1'b0;
        #3;
        clr = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clr = 1'b0; IR_Data = 32'h0; mem_ready = 1'b1;
        #12;
        checks++;
        if (outs !== 56'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: outs=%h run=%b, expected outs=0 run=0", outs, run);
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if (run !== 1'b0 || PC_select !== 1'b0) begin
            errors++;
            $display("FAIL release_before_edge: run=%b PC_select=%b, expected 0 0", run, PC_select);
        end
        step();
        checks++;
        if ({PC_select, MAR_enable, PC_increment_enable, run} !== 4'b1111) begin
            errors++;
            $display("FAIL first_T0: sel/mar/inc/run=%b expected 1111",
                     {PC_select, MAR_enable, PC_increment_enable, run});
        end
        // abort mid-instruction in T4 of an add
        IR_Data = 32'h1A920000;
        repeat (4) step();
        checks++;
        if (Z_enable !== 1'b1) begin
            errors++;
            $display("FAIL reach_T4: Z_enable=%b expected 1", Z_enable);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (outs !== 56'd0 || run !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: outs=%h run=%b expected outs=0 run=0", outs, run);
        end
        #2;
        clr = 1'b1;
        step();
        checks++;
        if ({PC_select, MAR_enable, PC_increment_enable, run} !== 4'b1111) begin
            errors++;
            $display("FAIL T0_after_abort: sel/mar/inc/run=%b expected 1111",
                     {PC_select, MAR_enable, PC_increment_enable, run});
        end
    endtask

    task automatic test_add();
        IR_Data = 32'h1A920000; mem_ready = 1'b1;
        restart();
        step();
        checks++;
        if (read !== 1'b1 || MDR_enable !== 1'b1) begin
            errors++;
            $display("FAIL add_T1: read=%b MDR_enable=%b expected 1 1", read, MDR_enable);
        end
        step();
        checks++;
        if (MDR_select !== 1'b1 || IR_enable !== 1'b1) begin
            errors++;
            $display("FAIL add_T2: MDR_select=%b IR_enable=%b expected 1 1", MDR_select, IR_enable);
        end
        step();
        checks++;
        if (r_select !== 16'h0004 || Y_enable !== 1'b1) begin
            errors++;
            $display("FAIL add_T3: r_select=%h Y_enable=%b expected 0004 1", r_select, Y_enable);
        end
        step();
        checks++;
        if (r_select !== 16'h0010 || alu_instruction !== 5'b00011 || Z_enable !== 1'b1) begin
            errors++;
            $display("FAIL add_T4: r_select=%h alu=%b Z_enable=%b expected 0010 00011 1",
                     r_select, alu_instruction, Z_enable);
        end
        step();
        checks++;
        if (Z_LO_select !== 1'b1 || r_enable !== 16'h0020 || r_select !== 16'h0000) begin
            errors++;
            $display("FAIL add_T5: Z_LO_select=%b r_enable=%h r_select=%h expected 1 0020 0000",
                     Z_LO_select, r_enable, r_select);
        end
        step();
        checks++;
        if (PC_select !== 1'b1 || r_enable !== 16'h0000) begin
            errors++;
            $display("FAIL add_back_T0: PC_select=%b r_enable=%h expected 1 0000", PC_select, r_enable);
        end
    endtask

    task automatic test_ld_wait();
        int n;
        IR_Data = 32'h01880010; mem_ready = 1'b1;   // ld R3, 0x10(R1)
        restart();
        repeat (4) step();                           // T4
        checks++;
        if (c_select !== 1'b1 || alu_instruction !== 5'd3) begin
            errors++;
            $display("FAIL ld_T4: c_select=%b alu=%0d expected 1 3", c_select, alu_instruction);
        end
        step();                                      // T5
        checks++;
        if (Z_LO_select !== 1'b1 || MAR_enable !== 1'b1) begin
            errors++;
            $display("FAIL ld_T5: Z_LO_select=%b MAR_enable=%b expected 1 1", Z_LO_select, MAR_enable);
        end
        mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!(read && MDR_enable)) break;
            n++;
            if (n == 4) mem_ready = 1'b1;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL ld_wait_len: read held %0d cycles, expected 4", n);
        end
        checks++;
        if (MDR_select !== 1'b1 || r_enable !== 16'h0008) begin
            errors++;
            $display("FAIL ld_T7: MDR_select=%b r_enable=%h expected 1 0008", MDR_select, r_enable);
        end
        step();
        checks++;
        if (PC_select !== 1'b1) begin
            errors++;
            $display("FAIL ld_back_T0: PC_select=%b expected 1", PC_select);
        end
    endtask

    task automatic test_st();
        IR_Data = 32'h12000020; mem_ready = 1'b1;   // st R4, 0x20(R0)
        restart();
        repeat (6) step();                           // T6
        checks++;
        if (r_select !== 16'h0010 || MDR_enable !== 1'b1 || read !== 1'b0) begin
            errors++;
            $display("FAIL st_T6: r_select=%h MDR_enable=%b read=%b expected 0010 1 0",
                     r_select, MDR_enable, read);
        end
        step();
        checks++;
        if (write !== 1'b1 || r_enable !== 16'h0000) begin
            errors++;
            $display("FAIL st_T7: write=%b r_enable=%h expected 1 0000", write, r_enable);
        end
        step();
        checks++;
        if (PC_select !== 1'b1 || write !== 1'b0) begin
            errors++;
            $display("FAIL st_back_T0: PC_select=%b write=%b expected 1 0", PC_select, write);
        end
    endtask

    task automatic test_timeout();
        IR_Data = 32'h0; mem_ready = 1'b0;
        restart();
        repeat (5) step();                           // T1 with wait count 4
        checks++;
        if (read !== 1'b1 || run !== 1'b1 || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_last_wait: read=%b run=%b mem_error=%b expected 1 1 0",
                     read, run, mem_error);
        end
        step();
        checks++;
        if (run !== 1'b0 || mem_error !== 1'b1 || outs !== 56'd1) begin
            errors++;
            $display("FAIL timeout_halt: run=%b mem_error=%b outs=%h expected 0 1 1",
                     run, mem_error, outs);
        end
        mem_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (run !== 1'b0 || mem_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: run=%b mem_error=%b expected 0 1", run, mem_error);
        end
        restart();
        checks++;
        if (mem_error !== 1'b0 || run !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cleared: mem_error=%b run=%b expected 0 1", mem_error, run);
        end
    endtask

    task automatic test_halt();
        int pc_seen;
        IR_Data = 32'hD8000000; mem_ready = 1'b1;
        restart();
        repeat (4) step();
        pc_seen = 0;
        checks++;
        if (run !== 1'b0 || outs !== 56'd0) begin
            errors++;
            $display("FAIL halt_enter: run=%b outs=%h expected 0 0", run, outs);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (PC_select || run) pc_seen++;
        end
        checks++;
        if (pc_seen !== 0) begin
            errors++;
            $display("FAIL halt_stays: %0d active cycles, expected 0", pc_seen);
        end
    endtask

    task automatic test_illegal();
        IR_Data = 32'h98000000; mem_ready = 1'b1;   // undefined opcode 19
        restart();
        repeat (3) step();
        checks++;
        if (illegal_op !== 1'b1 || run !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pulse: illegal_op=%b run=%b expected 1 1", illegal_op, run);
        end
        step();
        checks++;
        if (illegal_op !== 1'b0 || PC_select !== 1'b1) begin
            errors++;
            $display("FAIL illegal_back_T0: illegal_op=%b PC_select=%b expected 0 1", illegal_op, PC_select);
        end
`ifndef MUL_DIV_EN
        IR_Data = 32'h80000000;                      // mul
        repeat (3) step();
        checks++;
        if (illegal_op !== 1'b1 || Y_enable !== 1'b0) begin
            errors++;
            $display("FAIL mul_illegal: illegal_op=%b Y_enable=%b expected 1 0", illegal_op, Y_enable);
        end
        step();
        checks++;
        if (illegal_op !== 1'b0 || PC_select !== 1'b1) begin
            errors++;
            $display("FAIL mul_back_T0: illegal_op=%b PC_select=%b expected 0 1", illegal_op, PC_select);
        end
`endif
    endtask

    task automatic test_back_to_back();
        IR_Data = 32'h8BC80000; mem_ready = 1'b1;   // neg R7, R9
        restart();
        repeat (3) step();
        checks++;
        if (r_select !== 16'h0200 || alu_instruction !== 5'd17 || Z_enable !== 1'b1) begin
            errors++;
            $display("FAIL neg_T3: r_select=%h alu=%0d Z_enable=%b expected 0200 17 1",
                     r_select, alu_instruction, Z_enable);
        end
        step();
        checks++;
        if (Z_LO_select !== 1'b1 || r_enable !== 16'h0080) begin
            errors++;
            $display("FAIL neg_T4: Z_LO_select=%b r_enable=%h expected 1 0080", Z_LO_select, r_enable);
        end
        step();
        IR_Data = 32'hC1000000;                      // mfhi R2
        checks++;
        if (PC_select !== 1'b1) begin
            errors++;
            $display("FAIL neg_back_T0: PC_select=%b expected 1", PC_select);
        end
        repeat (3) step();
        checks++;
        if (HI_select !== 1'b1 || r_enable !== 16'h0004 || r_select !== 16'h0000) begin
            errors++;
            $display("FAIL mfhi_T3: HI_select=%b r_enable=%h r_select=%h expected 1 0004 0000",
                     HI_select, r_enable, r_select);
        end
        step();
        checks++;
        if (PC_select !== 1'b1 || HI_select !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_back_T0: PC_select=%b HI_select=%b expected 1 0", PC_select, HI_select);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b0;
        IR_Data = 32'h0;
        mem_ready = 1'b1;
        test_reset();
        test_add();
        test_ld_wait();
        test_st();
        test_timeout();
        test_halt();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: maximum number of cycles to wait for mem_ready before declaring a memory fault (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-low.
REQ-004 IR_Data  input  32  current instruction: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc, [18:0] C.
REQ-005 mem_ready  input  1  memory completed the pending read or write this cycle.
REQ-006 r_enable  output  16  one-hot write enable for r0..r15.
REQ-007 r_select  output  16  one-hot bus-drive select for r0..r15.
REQ-008 PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable  output  1 each  datapath register loads.
REQ-009 PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select, c_select  output  1 each  bus-source selects; at most one select (including r_select) is high in any cycle.
REQ-010 read, write  output  1 each  read: MDR loads from memory and a memory read is requested; write: a memory write is requested.
REQ-011 alu_instruction  output  5  ALU opcode; 0 when unused.
REQ-012 run, illegal_op, mem_error  output  1 each  running status, one-cycle undefined-opcode pulse, sticky memory-timeout flag.

Function
REQ-013 Moore FSM with states T0..T7 and HALT; all outputs decode from state, IR_Data, and the wait counter.
REQ-014 Fetch: T0 = PC_select, MAR_enable, PC_increment_enable; T1 = read, MDR_enable; T2 = MDR_select, IR_enable.
REQ-015 Execute begins at T3 and decodes IR_Data opcode (codes are defined in the package); the final step of every instruction returns to T0.
REQ-016 ALU register ops (add, sub, and, or, shr, shra, shl, ror, rol): T3 = Rb out, Y_enable; T4 = Rc out, alu_instruction=opcode, Z_enable; T5 = Z_LO_select, Ra in.
REQ-017 Immediate ops (addi, andi, ori, ldi): as REQ-016, but T4 uses c_select; alu_instruction is the add, and, or, or add code respectively.
REQ-018 ld: T3..T4 as addi; T5 = Z_LO_select, MAR_enable; T6 = read, MDR_enable; T7 = MDR_select, Ra in.
REQ-019 st: T3..T5 as ld; T6 = Ra out, MDR_enable with read=0; T7 = write.
REQ-020 neg and not: T3 = Rb out, alu_instruction=opcode, Z_enable; T4 = Z_LO_select, Ra in.
REQ-021 mfhi and mflo: T3 = HI_select or LO_select, Ra in.
REQ-022 nop: T3 returns to T0; halt: T3 goes to HALT; HALT drives run=0 with all other outputs 0, and is left only by reset.
REQ-023 Memory wait: states T1, T6 (ld) and T7 (st) hold state and outputs while mem_ready=0, and advance on the edge where mem_ready=1.
REQ-024 The wait counter is 8 bits, clears on each state change, and increments each held cycle.
REQ-025 When the wait counter reaches WAIT_LIMIT in a wait state, the FSM goes to HALT and mem_error is set; mem_error is cleared only by reset.
REQ-026 An undefined opcode pulses illegal_op in T3 and returns to T0.
REQ-027 run=1 in every state except HALT.

Reset
REQ-028 While clr=0, state=T0, all outputs are 0, run=0, and the wait counter=0.
REQ-029 Assertion mid-instruction aborts it immediately with no further enables; the first edge after release begins T0 with run=1.

Configuration
REQ-030 Macro MUL_DIV_EN defined: mul and div are supported: T3 = Ra out, Y_enable; T4 = Rb out, alu_instruction=opcode, Z_enable; T5 = Z_LO_select, LO_enable; T6 = Z_HI_select, HI_enable.
REQ-031 Macro MUL_DIV_EN absent: mul and div are treated as undefined opcodes per REQ-026.

Structure
REQ-032 Shared package holds the opcode constants, the state enumeration, and the IR field bit positions.
REQ-033 One sub-module, reg_field_decoder, converts a 4-bit register field to a 16-bit one-hot value; it is instantiated for the Ra, Rb and Rc fields.

Verification
REQ-034 Reset: clr=0 mid-T4 -> all outputs 0 and run=0 asynchronously; after release, T0 has PC_select=1, MAR_enable=1, PC_increment_enable=1.
REQ-035 add R5,R2,R4 (IR=0x1A920000), mem_ready=1 -> T3 r_select=0x0004 and Y_enable; T4 r_select=0x0010, alu_instruction=00011, Z_enable; T5 Z_LO_select, r_enable=0x0020; back in T0 six cycles after fetch start.
REQ-036 ld with mem_ready low for 3 cycles in T6 -> read=1 and MDR_enable=1 held 4 cycles; T7 MDR_select with r_enable of Ra.
REQ-037 WAIT_LIMIT=4 with mem_ready stuck at 0 in T1 -> after 4 held cycles, HALT with mem_error=1 and run=0.
REQ-038 halt (IR=0xD8000000) -> run=0 and no further PC_select; mul (IR=0x80000000) built without MUL_DIV_EN -> one-cycle illegal_op pulse, then T0.
